rx_frame_ctrl: RTL and testbench

Sequencing controller for the UART receive datapath: start detector, SIPO shifter, parity checker and stop-bit checker. It oversamples the serial line on a baud tick and tracks frame position. It issues the single-cycle shift, parity_load and check_stop strobes at bit centres. It also collects error status and presents each received frame to the host through a valid/ack handshake, with overrun detection.

---
 rtl/rx_frame_ctrl_if.sv | 46 ++++
 rtl/rx_frame_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_ctrl_if.sv
// Signal bundle between the UART receive sequencer, its datapath blocks and the host.
// master = sequencer side, slave = datapath/host/environment side.
interface rx_frame_ctrl_if;
  logic baud_tick;
  logic rx_in;
  logic parity_bit_error;
  logic shift;
  logic parity_load;
  logic check_stop;
  logic rx_busy;
  logic rx_valid;
  logic rx_ack;
  logic parity_err;
  logic frame_err;
  logic overrun_err;

  modport master (
    input  baud_tick,
    input  rx_in,
    input  parity_bit_error,
    input  rx_ack,
    output shift,
    output parity_load,
    output check_stop,
    output rx_busy,
    output rx_valid,
    output parity_err,
    output frame_err,
    output overrun_err
  );

  modport slave (
    output baud_tick,
    output rx_in,
    output parity_bit_error,
    output rx_ack,
    input  shift,
    input  parity_load,
    input  check_stop,
    input  rx_busy,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  overrun_err
  );
endinterface

// File: rtl/rx_frame_ctrl.sv
// UART receive sequencer: oversampled frame tracking, bit-centre strobes to the
// datapath, error collection and valid/ack presentation with overrun detection.
module rx_frame_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1
) (
  input logic          clk,
  input logic          rstn,
  rx_frame_ctrl_if.master bus
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] C_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_END  = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    C_LAST = 4'(DATA_BITS - 1);

  // IDLE: line idle | START: verify start at mid | DATA: shift bits | PARITY: parity bit | STOP: stop bit
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_meta;
  logic          r_rx_s;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    r_bit_cnt;
  logic [3:0]    w_bit_nxt;
  logic          r_armed;
  logic          w_armed_nxt;
  logic          w_shift;
  logic          w_parity_load;
  logic          w_check_stop;
  logic          w_at_mid;
  logic          w_at_end;

  logic r_par_cap;
  logic r_par_pend;
  logic r_frame_pend;
  logic r_cmpl_dly;
  logic w_cmpl;
  logic w_par_flag;
  logic w_frame_flag;

  logic r_rx_valid;
  logic r_parity_err;
  logic r_frame_err;
  logic r_overrun;

  assign w_at_mid = bus.baud_tick && (r_cnt == C_MID);
  assign w_at_end = bus.baud_tick && (r_cnt == C_END);

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_meta       <= 1'b1;
      r_rx_s       <= 1'b1;
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit_cnt    <= '0;
      r_armed      <= 1'b0;
      r_par_cap    <= 1'b0;
      r_par_pend   <= 1'b0;
      r_frame_pend <= 1'b0;
      r_cmpl_dly   <= 1'b0;
    end else begin
      r_meta     <= bus.rx_in;
      r_rx_s     <= r_meta;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_armed    <= w_armed_nxt;
      r_par_cap  <= w_parity_load;
      if (r_par_cap) begin
        r_par_pend <= bus.parity_bit_error;
      end
      if (w_check_stop) begin
        r_frame_pend <= ~r_rx_s;
      end
      r_cmpl_dly <= (PARITY_EN != 0) && w_check_stop;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_armed_nxt   = r_armed;
    w_shift       = 1'b0;
    w_parity_load = 1'b0;
    w_check_stop  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (bus.baud_tick) begin
          if (r_rx_s) begin
            w_armed_nxt = 1'b1;
          end else if (r_armed) begin
            w_state_nxt = S_START;
          end
        end
      end

      S_START: begin
        if (w_at_mid) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end else if (bus.baud_tick) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (w_at_end) begin
          w_cnt_nxt = '0;
          w_shift   = 1'b1;
          w_bit_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == C_LAST) begin
            w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end else if (bus.baud_tick) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_PARITY: begin
        if (w_at_end) begin
          w_cnt_nxt     = '0;
          w_parity_load = 1'b1;
          w_state_nxt   = S_STOP;
        end else if (bus.baud_tick) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (w_at_end) begin
          w_cnt_nxt    = '0;
          w_check_stop = 1'b1;
          w_armed_nxt  = 1'b0;
          w_state_nxt  = S_IDLE;
        end else if (bus.baud_tick) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // With parity, completion waits one clk so the captured parity result is included.
  assign w_cmpl       = (PARITY_EN != 0) ? r_cmpl_dly : w_check_stop;
  assign w_par_flag   = (PARITY_EN != 0) ? r_par_pend : 1'b0;
  assign w_frame_flag = (PARITY_EN != 0) ? r_frame_pend : ~r_rx_s;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_cmpl) begin
      if (!r_rx_valid || bus.rx_ack) begin
        r_rx_valid   <= 1'b1;
        r_parity_err <= w_par_flag;
        r_frame_err  <= w_frame_flag;
        r_overrun    <= 1'b0;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (bus.rx_ack && r_rx_valid) begin
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end
  end

  assign bus.shift       = w_shift       & ~rstn;
  assign bus.parity_load = w_parity_load & ~rstn;
  assign bus.check_stop  = w_check_stop  & ~rstn;
  assign bus.rx_busy     = (r_state != S_IDLE) & ~rstn;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.parity_err  = r_parity_err;
  assign bus.frame_err   = r_frame_err;
  assign bus.overrun_err = r_overrun;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: frames driven serially, received data rebuilt
// from shift strobes and checked against a scoreboard, status checked after each frame.
module tb_rx_frame_ctrl;
  localparam int OS = 16;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rx_frame_ctrl_if bus_if ();

  rx_frame_ctrl #(
    .OVERSAMPLE(OS),
    .DATA_BITS (DB),
    .PARITY_EN (1)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_if)
  );

  logic [7:0] sb_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int shift_total = 0;
  int m_shifts = 0;
  int m_par = 0;
  int last_shift_cyc = 0;
  int excl_viol = 0;
  int rst_strobe = 0;
  logic [7:0] m_data = 8'h00;
  logic prev_valid = 1'b0;
  longint t_valid = 0;
  longint t_drive = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: rebuilds each frame from the shift strobes and pops the scoreboard at check_stop.
  initial begin
    logic [7:0] exp_d;
    forever begin
      @(negedge clk);
      cyc++;
      if (rstn) begin
        if (bus_if.shift || bus_if.parity_load || bus_if.check_stop) rst_strobe++;
        m_shifts = 0;
        m_par = 0;
        m_data = 8'h00;
        prev_valid = 1'b0;
        continue;
      end
      if ($countones({bus_if.shift, bus_if.parity_load, bus_if.check_stop}) > 1) excl_viol++;
      if (bus_if.rx_valid === 1'b1 && !prev_valid) t_valid = longint'($time);
      prev_valid = (bus_if.rx_valid === 1'b1);
      if (bus_if.shift) begin
        if (m_shifts > 0) check("shift_spacing", cyc - last_shift_cyc, OS);
        last_shift_cyc = cyc;
        m_data = {bus_if.rx_in, m_data[7:1]};
        m_shifts++;
        shift_total++;
      end
      if (bus_if.parity_load) m_par++;
      if (bus_if.check_stop) begin
        check("sb_nonempty", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          exp_d = sb_q.pop_front();
          check("frame_data", m_data, exp_d);
        end
        check("shift_count", m_shifts, DB);
        check("parity_load_count", m_par, 1);
        m_shifts = 0;
        m_par = 0;
        m_data = 8'h00;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic perr, input logic stop_b,
                            input logic after_lvl);
    sb_q.push_back(d);
    bus_if.parity_bit_error = perr;
    bus_if.rx_in = 1'b0;
    t_drive = longint'($time);
    clks(OS);
    for (int i = 0; i < DB; i++) begin
      bus_if.rx_in = d[i];
      clks(OS);
    end
    bus_if.rx_in = ^d;
    clks(OS);
    bus_if.rx_in = stop_b;
    clks(OS);
    bus_if.rx_in = after_lvl;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus_if.rx_valid !== 1'b1 && n < 100) begin
      clks(1);
      n++;
    end
    check(tag, bus_if.rx_valid, 1);
  endtask

  task automatic check_status(input string tag, input logic v, input logic pe, input logic fe,
                              input logic ov);
    check({tag, "_valid"}, bus_if.rx_valid, v);
    check({tag, "_parity_err"}, bus_if.parity_err, pe);
    check({tag, "_frame_err"}, bus_if.frame_err, fe);
    check({tag, "_overrun"}, bus_if.overrun_err, ov);
  endtask

  task automatic ack();
    bus_if.rx_ack = 1'b1;
    clks(1);
    bus_if.rx_ack = 1'b0;
  endtask

  task automatic ack_at_completion();
    int n = 0;
    while (bus_if.check_stop !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ack_sync_found", bus_if.check_stop, 1);
    @(posedge clk);
    #1 bus_if.rx_ack = 1'b1;
    @(posedge clk);
    #1 bus_if.rx_ack = 1'b0;
  endtask

  initial begin
    int base;
    int busy_cnt;
    logic seen;
    longint lat;
    logic [7:0] d5a;

    rstn = 1'b1;
    bus_if.baud_tick = 1'b1;
    bus_if.rx_in = 1'b1;
    bus_if.parity_bit_error = 1'b0;
    bus_if.rx_ack = 1'b0;
    @(negedge clk);
    check("rst_shift_gated", bus_if.shift, 0);
    check("rst_busy_gated", bus_if.rx_busy, 0);
    clks(3);
    rstn = 1'b0;
    check_status("reset", 0, 0, 0, 0);
    check("reset_busy", bus_if.rx_busy, 0);
    clks(20);

    // Nominal frame
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    wait_valid("nominal_valid_seen");
    lat = (t_valid - t_drive) / 10;
    check("latency_in_range", 32'(lat >= 170 && lat <= 172), 1);
    check_status("nominal", 1, 0, 0, 0);
    ack();
    check_status("nominal_ack", 0, 0, 0, 0);
    ack();
    check_status("idle_ack_ignored", 0, 0, 0, 0);
    clks(10);

    // Glitch rejection
    base = shift_total;
    seen = 1'b0;
    bus_if.rx_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) bus_if.rx_in = 1'b1;
      clks(1);
      if (bus_if.rx_busy === 1'b1) seen = 1'b1;
    end
    check("glitch_start_entered", seen, 1);
    clks(10);
    check("glitch_back_idle", bus_if.rx_busy, 0);
    check("glitch_no_shift", shift_total - base, 0);
    check("glitch_no_valid", bus_if.rx_valid, 0);

    // Parity error
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1);
    wait_valid("parity_valid_seen");
    check_status("parity", 1, 1, 0, 0);
    ack();
    bus_if.parity_bit_error = 1'b0;
    clks(10);

    // Break: stop bit low and line held low afterwards
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    wait_valid("break_valid_seen");
    check_status("break", 1, 0, 1, 0);
    busy_cnt = 0;
    base = shift_total;
    for (int i = 0; i < 64; i++) begin
      clks(1);
      if (bus_if.rx_busy !== 1'b0) busy_cnt++;
    end
    check("break_no_restart", busy_cnt, 0);
    check("break_no_shift", shift_total - base, 0);
    ack();
    check_status("break_ack", 0, 0, 0, 0);
    bus_if.rx_in = 1'b1;
    clks(20);

    // Overrun: two frames without ack; the first frame's flags are retained
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
    clks(4);
    check_status("overrun", 1, 1, 0, 1);
    ack();
    check_status("overrun_ack", 0, 0, 0, 0);
    clks(10);

    // Ack coincident with the second frame's completion
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    wait_valid("simul_first_valid");
    check_status("simul_first", 1, 0, 0, 0);
    fork
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      ack_at_completion();
    join
    clks(2);
    check_status("simul_second", 1, 0, 1, 0);
    clks(10);

    // Reset during the 4th data bit, then a clean frame
    d5a = 8'h5A;
    bus_if.rx_in = 1'b0;
    clks(OS);
    for (int i = 0; i < 3; i++) begin
      bus_if.rx_in = d5a[i];
      clks(OS);
    end
    bus_if.rx_in = d5a[3];
    clks(OS / 2);
    rstn = 1'b1;
    clks(1);
    rstn = 1'b0;
    bus_if.rx_in = 1'b1;
    check_status("midframe_reset", 0, 0, 0, 0);
    check("midframe_reset_busy", bus_if.rx_busy, 0);
    clks(40);
    check("post_reset_idle", bus_if.rx_busy, 0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    wait_valid("post_reset_valid_seen");
    check_status("post_reset", 1, 0, 0, 0);
    ack();
    clks(10);

    check("strobe_exclusive", excl_viol, 0);
    check("no_strobe_in_reset", rst_strobe, 0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
